// File: rtl/mem_stage_if.sv
// Bus bundle between the execute/memory pipeline boundary and mem_stage.
// Optional MEM_ALIGN_CHK_EN adds the sticky err_align status signal.
interface mem_stage_if;
  logic [2:0]  in_M;
  logic [1:0]  in_WB;
  logic [31:0] in_add;
  logic        in_flag;
  logic [31:0] in_res;
  logic [31:0] in_dat2;
  logic [4:0]  in_mux;
  logic [27:0] in_ShfJ;
  logic        J_in;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [1:0]  ou_WB;
  logic [31:0] ou_rdata;
  logic [31:0] ou_res;
  logic [4:0]  ou_mux;
`ifdef MEM_ALIGN_CHK_EN
  logic        err_align;
`endif

  modport master (
    output in_M, in_WB, in_add, in_flag, in_res, in_dat2, in_mux, in_ShfJ, J_in,
    input  pc_src, pc_target, ou_WB, ou_rdata, ou_res, ou_mux
`ifdef MEM_ALIGN_CHK_EN
    , input err_align
`endif
  );

  modport slave (
    input  in_M, in_WB, in_add, in_flag, in_res, in_dat2, in_mux, in_ShfJ, J_in,
    output pc_src, pc_target, ou_WB, ou_rdata, ou_res, ou_mux
`ifdef MEM_ALIGN_CHK_EN
    , output err_align
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word data memory, MEM/WB pipeline register and
// branch/jump redirect. Optional macro MEM_ALIGN_CHK_EN enables the
// misaligned-access check (suppresses the access, sets sticky err_align).
module mem_stage #(
  parameter int unsigned ADDR_BITS = 6
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [31:0]          r_mem [DEPTH];
  logic [1:0]           r_wb;
  logic [31:0]          r_rdata;
  logic [31:0]          r_res;
  logic [4:0]           r_mux;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          w_rdata;
  logic                 w_mis;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_we;

  // Word index; upper address bits are dropped so accesses wrap.
  assign w_idx   = bus.in_res[ADDR_BITS+1:2];
  assign w_rdata = r_mem[w_idx];

`ifdef MEM_ALIGN_CHK_EN
  logic r_err;
  assign w_mis = (bus.in_M[1] | bus.in_M[0]) & (bus.in_res[1:0] != 2'b00);
  assign bus.err_align = r_err;
`else
  assign w_mis = 1'b0;
`endif

  assign w_rd = bus.in_M[1] & ~w_mis;
  assign w_wr = bus.in_M[0] & ~w_mis;
  // Writes are blocked while reset is held; contents survive reset.
  assign w_we = w_wr & rst_n;

  // Redirect is purely combinational; a jump overrides a taken branch.
  assign bus.pc_src    = bus.J_in | (bus.in_M[2] & bus.in_flag);
  assign bus.pc_target = bus.J_in ? {bus.in_add[31:28], bus.in_ShfJ} : bus.in_add;

  assign bus.ou_WB    = r_wb;
  assign bus.ou_rdata = r_rdata;
  assign bus.ou_res   = r_res;
  assign bus.ou_mux   = r_mux;

  // Data memory write port (no reset on storage).
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= bus.in_dat2;
    end
  end

  // MEM/WB pipeline register; read data is the pre-store contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb    <= 2'b00;
      r_rdata <= 32'h0;
      r_res   <= 32'h0;
      r_mux   <= 5'h0;
    end else begin
      r_wb    <= {bus.in_WB[1] & ~w_mis, bus.in_WB[0]};
      r_rdata <= w_rd ? w_rdata : 32'h0;
      r_res   <= bus.in_res;
      r_mux   <= bus.in_mux;
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_mis) begin
      r_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (ADDR_BITS=6), randomized stimulus against
// an array-based memory model. Define MEM_ALIGN_CHK_EN to cover the align check.
module tb_mem_stage;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  logic [31:0] ref_mem [DEPTH];
  logic        ref_err = 1'b0;

  mem_stage_if bus ();

  mem_stage #(.ADDR_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] exp_target(input logic j, input logic [31:0] add,
                                             input logic [27:0] shf);
    if (j) return (add & 32'hF000_0000) | {4'h0, shf};
    return add;
  endfunction

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_M = 3'b000; bus.in_WB = 2'b00; bus.in_add = 32'h0; bus.in_flag = 1'b0;
    bus.in_res = 32'h0; bus.in_dat2 = 32'h0; bus.in_mux = 5'h0; bus.in_ShfJ = 28'h0;
    bus.J_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({bus.ou_WB, bus.ou_rdata, bus.ou_res, bus.ou_mux} !== 71'h0)
      $display("FAIL reset_outs got %h %h %h %h exp 0", bus.ou_WB, bus.ou_rdata, bus.ou_res, bus.ou_mux);
    else pass_cnt++;
`ifdef MEM_ALIGN_CHK_EN
    chk_cnt++; if (bus.err_align !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err_align);
    else pass_cnt++;
`endif
    bus.J_in = 1'b1; bus.in_ShfJ = 28'h0000123; bus.in_add = 32'hA000_0000;
    #1;
    chk_cnt++; if (bus.pc_src !== 1'b1 || bus.pc_target !== 32'hA000_0123)
      $display("FAIL reset_redirect got %b %h exp 1 a0000123", bus.pc_src, bus.pc_target);
    else pass_cnt++;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] d, a;
    logic [1:0]  wb;
    logic [4:0]  mx;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom; wb = 2'($urandom); mx = 5'($urandom); a = 32'(i * 4);
      bus.in_M = 3'b001; bus.in_res = a; bus.in_dat2 = d; bus.in_WB = wb; bus.in_mux = mx;
      step();
      ref_mem[i] = d;
      chk_cnt++; if (bus.ou_rdata !== 32'h0 || bus.ou_res !== a || bus.ou_mux !== mx || bus.ou_WB !== wb)
        $display("FAIL fill_%0d got %h %h %h %b exp 0 %h %h %b", i, bus.ou_rdata, bus.ou_res, bus.ou_mux, bus.ou_WB, a, mx, wb);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_store_load();
    bus.in_M = 3'b001; bus.in_res = 32'h10; bus.in_dat2 = 32'hDEAD_BEEF; bus.in_WB = 2'b00;
    step();
    ref_mem[4] = 32'hDEAD_BEEF;
    bus.in_M = 3'b010; bus.in_WB = 2'b11; bus.in_res = 32'h10;
    step();
    chk_cnt++; if (bus.ou_rdata !== 32'hDEAD_BEEF || bus.ou_WB !== 2'b11)
      $display("FAIL store_load got %h %b exp deadbeef 11", bus.ou_rdata, bus.ou_WB);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    bus.in_M = 3'b001; bus.in_res = 32'h10; bus.in_dat2 = 32'h1111;
    step();
    bus.in_M = 3'b011; bus.in_dat2 = 32'h2222;
    step();
    chk_cnt++; if (bus.ou_rdata !== 32'h1111)
      $display("FAIL same_cycle_old got %h exp 00001111", bus.ou_rdata);
    else pass_cnt++;
    bus.in_M = 3'b010;
    step();
    ref_mem[4] = 32'h2222;
    chk_cnt++; if (bus.ou_rdata !== 32'h2222)
      $display("FAIL same_cycle_new got %h exp 00002222", bus.ou_rdata);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_redirect();
    logic [31:0] add;
    logic [27:0] shf;
    logic        j, br, fl, exp_src;
    bus.in_M = 3'b100; bus.in_flag = 1'b1; bus.in_add = 32'h0040_0020; bus.J_in = 1'b0;
    #1;
    chk_cnt++; if (bus.pc_src !== 1'b1 || bus.pc_target !== 32'h0040_0020)
      $display("FAIL branch_taken got %b %h exp 1 00400020", bus.pc_src, bus.pc_target);
    else pass_cnt++;
    bus.J_in = 1'b1; bus.in_ShfJ = 28'h0000040;
    #1;
    chk_cnt++; if (bus.pc_src !== 1'b1 || bus.pc_target !== 32'h0000_0040)
      $display("FAIL jump_priority got %b %h exp 1 00000040", bus.pc_src, bus.pc_target);
    else pass_cnt++;
    bus.J_in = 1'b0; bus.in_flag = 1'b0;
    #1;
    chk_cnt++; if (bus.pc_src !== 1'b0 || bus.pc_target !== 32'h0040_0020)
      $display("FAIL branch_not_taken got %b %h exp 0 00400020", bus.pc_src, bus.pc_target);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      add = $urandom; shf = 28'($urandom); j = 1'($urandom); br = 1'($urandom); fl = 1'($urandom);
      bus.in_add = add; bus.in_ShfJ = shf; bus.J_in = j; bus.in_M = {br, 2'b00}; bus.in_flag = fl;
      #1;
      exp_src = j || (br && fl);
      chk_cnt++; if (bus.pc_src !== exp_src || bus.pc_target !== exp_target(j, add, shf))
        $display("FAIL redirect_rand_%0d got %b %h exp %b %h", i, bus.pc_src, bus.pc_target, exp_src, exp_target(j, add, shf));
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    bus.in_M = 3'b001; bus.in_res = 32'h100; bus.in_dat2 = 32'h5;
    step();
    ref_mem[0] = 32'h5;
    bus.in_M = 3'b010; bus.in_res = 32'h0;
    step();
    chk_cnt++; if (bus.ou_rdata !== 32'h5) $display("FAIL wrap got %h exp 00000005", bus.ou_rdata);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_async_reset();
    bus.in_M = 3'b010; bus.in_res = 32'h14; bus.in_WB = 2'b11; bus.in_mux = 5'd9;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({bus.ou_WB, bus.ou_rdata, bus.ou_res, bus.ou_mux} !== 71'h0)
      $display("FAIL async_reset got %h %h %h %h exp 0", bus.ou_WB, bus.ou_rdata, bus.ou_res, bus.ou_mux);
    else pass_cnt++;
    ref_err = 1'b0;
    bus.in_M = 3'b001; bus.in_dat2 = 32'hCAFE_F00D;
    step();
    chk_cnt++; if ({bus.ou_WB, bus.ou_rdata, bus.ou_res, bus.ou_mux} !== 71'h0)
      $display("FAIL reset_hold got %h %h %h %h exp 0", bus.ou_WB, bus.ou_rdata, bus.ou_res, bus.ou_mux);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    bus.in_M = 3'b010; bus.in_res = 32'h14; bus.in_WB = 2'b10; bus.in_mux = 5'd7;
    step();
    chk_cnt++; if (bus.ou_rdata !== ref_mem[5] || bus.ou_WB !== 2'b10 || bus.ou_res !== 32'h14 || bus.ou_mux !== 5'd7)
      $display("FAIL after_release got %h %b %h %h exp %h 10 14 07", bus.ou_rdata, bus.ou_WB, bus.ou_res, bus.ou_mux, ref_mem[5]);
    else pass_cnt++;
    idle_inputs();
  endtask

`ifdef MEM_ALIGN_CHK_EN
  task automatic test_align();
    chk_cnt++; if (bus.err_align !== 1'b0) $display("FAIL align_clear got %b exp 0", bus.err_align);
    else pass_cnt++;
    bus.in_M = 3'b001; bus.in_res = 32'h12; bus.in_dat2 = 32'hBAD0_BAD0; bus.in_WB = 2'b11;
    step();
    ref_err = 1'b1;
    chk_cnt++; if (bus.err_align !== 1'b1 || bus.ou_WB !== 2'b01 || bus.ou_rdata !== 32'h0)
      $display("FAIL align_store got %b %b %h exp 1 01 0", bus.err_align, bus.ou_WB, bus.ou_rdata);
    else pass_cnt++;
    bus.in_M = 3'b010; bus.in_res = 32'h10; bus.in_WB = 2'b11;
    step();
    chk_cnt++; if (bus.err_align !== 1'b1 || bus.ou_rdata !== ref_mem[4] || bus.ou_WB !== 2'b11)
      $display("FAIL align_unchanged got %b %h %b exp 1 %h 11", bus.err_align, bus.ou_rdata, bus.ou_WB, ref_mem[4]);
    else pass_cnt++;
    bus.in_res = 32'h11;
    step();
    chk_cnt++; if (bus.ou_rdata !== 32'h0 || bus.ou_WB !== 2'b01)
      $display("FAIL align_load got %h %b exp 0 01", bus.ou_rdata, bus.ou_WB);
    else pass_cnt++;
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [2:0]  m;
    logic [1:0]  wb, exp_wb;
    logic [31:0] a, d, exp_rd;
    logic [4:0]  mx;
    logic        mis;
    int          k;
    for (int i = 0; i < 200; i++) begin
      m = 3'($urandom); wb = 2'($urandom); a = $urandom & 32'h0000_03FF;
      d = $urandom; mx = 5'($urandom);
      bus.in_M = m; bus.in_WB = wb; bus.in_res = a; bus.in_dat2 = d; bus.in_mux = mx;
      k = widx(a);
`ifdef MEM_ALIGN_CHK_EN
      mis = (m[1] || m[0]) && (a % 4 != 0);
`else
      mis = 1'b0;
`endif
      exp_rd = (m[1] && !mis) ? ref_mem[k] : 32'h0;
      exp_wb = mis ? (wb & 2'b01) : wb;
      if (m[0] && !mis) ref_mem[k] = d;
      if (mis) ref_err = 1'b1;
      step();
      chk_cnt++; if (bus.ou_rdata !== exp_rd || bus.ou_WB !== exp_wb || bus.ou_res !== a || bus.ou_mux !== mx)
        $display("FAIL rand_%0d got %h %b %h %h exp %h %b %h %h", i, bus.ou_rdata, bus.ou_WB, bus.ou_res, bus.ou_mux, exp_rd, exp_wb, a, mx);
      else pass_cnt++;
`ifdef MEM_ALIGN_CHK_EN
      chk_cnt++; if (bus.err_align !== ref_err)
        $display("FAIL rand_err_%0d got %b exp %b", i, bus.err_align, ref_err);
      else pass_cnt++;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_same_cycle();
    test_redirect();
    test_wrap();
    test_async_reset();
`ifdef MEM_ALIGN_CHK_EN
    test_align();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
